mac_burst_ctrl: RTL and testbench

- Parametrised memory access controller (MAC) for the DLX control path; replaces the fixed single-beat MAC.
- Converts level MR/MW requests from the DLX control state machine into bus cycles using AS_N/WR_N/ACK_N.
- Supports multi-beat bursts with address auto-increment and an ACK timeout.
- Generates BUSY and STOP_N to stall the core until the final beat completes.

---
 rtl/mac_burst_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_mac_burst_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_burst_ctrl.sv
// mac_burst_ctrl: memory access controller for the DLX control path.
// Turns level MR/MW requests into AS_N/WR_N/ACK_N bus cycles, with
// multi-beat bursts, address auto-increment and core stall via STOP_N.
// Optional feature macro: MAC_TIMEOUT_EN (ACK timeout counter and abort
// path). When it is undefined, ACCESS waits for ACK_N indefinitely and
// TIMEOUT_ERR is tied low.
module mac_burst_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MAX_BURST   = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           MR,
  input  logic                           MW,
  input  logic [ADDR_W-1:0]              ADDR_IN,
  input  logic [$clog2(MAX_BURST+1)-1:0] BURST_LEN,
  input  logic [DATA_W-1:0]              WDATA,
  input  logic [DATA_W-1:0]              RDATA_IN,
  input  logic                           ACK_N,
  input  logic                           ERR_CLR,
  output logic                           AS_N,
  output logic                           WR_N,
  output logic [ADDR_W-1:0]              BUS_ADDR,
  output logic [DATA_W-1:0]              BUS_WDATA,
  output logic                           WDATA_NEXT,
  output logic [DATA_W-1:0]              RDATA_OUT,
  output logic                           RDATA_VLD,
  output logic                           BUSY,
  output logic                           STOP_N,
  output logic                           TIMEOUT_ERR,
  output logic                           PROTO_ERR,
  output logic [1:0]                     MAC_STATE
);

  localparam int LEN_W = $clog2(MAX_BURST + 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_GAP    = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  // Reject parameter sets the datapath cannot honour.
  if (((DATA_W % 8) != 0) || (MAX_BURST < 1) || (TIMEOUT_CYC < 1)) begin : g_param_check
    $error("mac_burst_ctrl: illegal parameter set");
  end

  state_t            state_r;
  logic              write_r;
  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  beat_r;
  logic              as_n_r;
  logic              wr_n_r;
  logic              busy_r;
  logic [DATA_W-1:0] rdata_r;
  logic              rdata_vld_r;
  logic              proto_err_r;

  logic              req_one_s;
  logic              req_both_s;
  logic              ack_s;
  logic              last_beat_s;
  logic              timeout_hit_s;
  logic [LEN_W-1:0]  eff_len_s;
  logic              stop_n_s;
  logic [DATA_W-1:0] bus_wdata_s;

  assign req_one_s   = MR ^ MW;
  assign req_both_s  = MR & MW;
  assign ack_s       = ~ACK_N;
  assign last_beat_s = (beat_r == (len_r - LEN_W'(1)));

  // Effective burst length: zero means one beat, oversize clamps to MAX_BURST.
  always_comb begin
    eff_len_s = BURST_LEN;
    if (BURST_LEN == '0) begin
      eff_len_s = LEN_W'(1);
    end else if (BURST_LEN > LEN_W'(MAX_BURST)) begin
      eff_len_s = LEN_W'(MAX_BURST);
    end else begin
      eff_len_s = BURST_LEN;
    end
  end

`ifdef MAC_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt_r;
  logic            timeout_err_r;

  // An ack in the same cycle always wins, since a hit requires ACK_N high.
  assign timeout_hit_s = (state_r == ST_ACCESS) && ACK_N && (to_cnt_r == TO_LAST);

  // Count unacknowledged ACCESS cycles; any other cycle restarts the count.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      to_cnt_r <= '0;
    end else if ((state_r == ST_ACCESS) && ACK_N && !timeout_hit_s) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= '0;
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      timeout_err_r <= 1'b0;
    end else if (timeout_hit_s) begin
      timeout_err_r <= 1'b1;
    end else if (ERR_CLR) begin
      timeout_err_r <= 1'b0;
    end
  end

  assign TIMEOUT_ERR = timeout_err_r;
`else
  assign timeout_hit_s = 1'b0;
  assign TIMEOUT_ERR   = 1'b0;
`endif

  // Sticky protocol-error flag for MR and MW requested together in IDLE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      proto_err_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && req_both_s) begin
      proto_err_r <= 1'b1;
    end else if (ERR_CLR) begin
      proto_err_r <= 1'b0;
    end
  end

  // Main controller FSM with registered bus strobes, address and read data.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r     <= ST_IDLE;
      write_r     <= 1'b0;
      addr_r      <= '0;
      len_r       <= '0;
      beat_r      <= '0;
      as_n_r      <= 1'b1;
      wr_n_r      <= 1'b1;
      busy_r      <= 1'b0;
      rdata_r     <= '0;
      rdata_vld_r <= 1'b0;
    end else begin
      rdata_vld_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_one_s) begin
            write_r <= MW;
            addr_r  <= ADDR_IN;
            len_r   <= eff_len_s;
            beat_r  <= '0;
            as_n_r  <= 1'b0;
            wr_n_r  <= ~MW;
            busy_r  <= 1'b1;
            state_r <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (ack_s) begin
            if (!write_r) begin
              rdata_r     <= RDATA_IN;
              rdata_vld_r <= 1'b1;
            end
            as_n_r <= 1'b1;
            wr_n_r <= 1'b1;
            if (last_beat_s) begin
              state_r <= ST_DONE;
            end else begin
              addr_r  <= addr_r + ADDR_STEP;
              beat_r  <= beat_r + LEN_W'(1);
              state_r <= ST_GAP;
            end
          end else if (timeout_hit_s) begin
            as_n_r  <= 1'b1;
            wr_n_r  <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_GAP: begin
          as_n_r  <= 1'b0;
          wr_n_r  <= ~write_r;
          state_r <= ST_ACCESS;
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          as_n_r  <= 1'b1;
          wr_n_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Stall the core from request accept until the final beat resolves.
  always_comb begin
    stop_n_s = 1'b1;
    case (state_r)
      ST_IDLE: begin
        stop_n_s = ~req_one_s;
      end
      ST_ACCESS: begin
        if ((ack_s && last_beat_s) || timeout_hit_s) begin
          stop_n_s = 1'b1;
        end else begin
          stop_n_s = 1'b0;
        end
      end
      ST_GAP: begin
        stop_n_s = 1'b0;
      end
      ST_DONE: begin
        stop_n_s = 1'b1;
      end
      default: begin
        stop_n_s = 1'b1;
      end
    endcase
  end

  // Write data is only driven onto the bus while a write request is active.
  always_comb begin
    bus_wdata_s = '0;
    if (write_r && (state_r != ST_IDLE)) begin
      bus_wdata_s = WDATA;
    end else begin
      bus_wdata_s = '0;
    end
  end

  assign AS_N       = as_n_r;
  assign WR_N       = wr_n_r;
  assign BUS_ADDR   = addr_r;
  assign BUS_WDATA  = bus_wdata_s;
  assign WDATA_NEXT = (state_r == ST_ACCESS) && write_r && ack_s;
  assign RDATA_OUT  = rdata_r;
  assign RDATA_VLD  = rdata_vld_r;
  assign BUSY       = busy_r;
  assign STOP_N     = stop_n_s;
  assign PROTO_ERR  = proto_err_r;
  assign MAC_STATE  = state_r;

endmodule

// File: tb/tb_mac_burst_ctrl.sv
// Testbench for mac_burst_ctrl: table of per-cycle vectors plus directed
// sequences for address wrap, burst clamp, reset mid-burst and timeout.
module tb_mac_burst_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MR, MW, ACK_N, ERR_CLR;
  logic [31:0] ADDR_IN, WDATA, RDATA_IN;
  logic [2:0]  BURST_LEN;
  logic        AS_N, WR_N, WDATA_NEXT, RDATA_VLD, BUSY, STOP_N, TIMEOUT_ERR, PROTO_ERR;
  logic [31:0] BUS_ADDR, BUS_WDATA, RDATA_OUT;
  logic [1:0]  MAC_STATE;

  int checks = 0;
  int errors = 0;

  mac_burst_ctrl dut (
    .CLK(CLK), .RESET(RESET), .MR(MR), .MW(MW), .ADDR_IN(ADDR_IN),
    .BURST_LEN(BURST_LEN), .WDATA(WDATA), .RDATA_IN(RDATA_IN), .ACK_N(ACK_N),
    .ERR_CLR(ERR_CLR), .AS_N(AS_N), .WR_N(WR_N), .BUS_ADDR(BUS_ADDR),
    .BUS_WDATA(BUS_WDATA), .WDATA_NEXT(WDATA_NEXT), .RDATA_OUT(RDATA_OUT),
    .RDATA_VLD(RDATA_VLD), .BUSY(BUSY), .STOP_N(STOP_N),
    .TIMEOUT_ERR(TIMEOUT_ERR), .PROTO_ERR(PROTO_ERR), .MAC_STATE(MAC_STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        mr, mw, an, clr;
    logic [31:0] ai;
    logic [2:0]  bl;
    logic [31:0] rd, wd;
    logic [1:0]  st;
    logic        as_n, wr_n, stop_n, busy, wnx, rvld, prot;
    logic [31:0] ea, er, ebw;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int mr, mw, an, clr, ai, bl, rd, wd,
                     input int st, as_n, wr_n, stop_n, busy, wnx, rvld, prot,
                     input int ea, er, ebw);
    vec_t r;
    r.mr = 1'(mr); r.mw = 1'(mw); r.an = 1'(an); r.clr = 1'(clr);
    r.ai = 32'(ai); r.bl = 3'(bl); r.rd = 32'(rd); r.wd = 32'(wd);
    r.st = 2'(st); r.as_n = 1'(as_n); r.wr_n = 1'(wr_n); r.stop_n = 1'(stop_n);
    r.busy = 1'(busy); r.wnx = 1'(wnx); r.rvld = 1'(rvld); r.prot = 1'(prot);
    r.ea = 32'(ea); r.er = 32'(er); r.ebw = 32'(ebw);
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc_cnt;
    int vld_cnt;
    logic [31:0] DB, W, X5, R3;
    DB = 32'hDEADBEEF; W = 32'hCAFE0001; X5 = 32'h55555555; R3 = 32'h12345678;

    // mr mw an clr ai bl rd wd | st as wr stop busy wnx rvld prot | ea er ebw
    add(0,0,0,0,'h100,1,0,0,   0,1,1,1,0,0,0,0, 'h000,0,0); // ACK_N low in IDLE: no effect
    add(1,0,1,0,'h100,1,0,0,   0,1,1,0,0,0,0,0, 'h000,0,0); // read accept
    add(1,0,1,0,'h999,1,0,0,   1,0,1,0,1,0,0,0, 'h100,0,0);
    add(1,0,1,0,'h999,1,0,0,   1,0,1,0,1,0,0,0, 'h100,0,0);
    add(1,0,0,0,'h999,1,DB,0,  1,0,1,1,1,0,0,0, 'h100,0,0); // ack on 3rd ACCESS cycle
    add(0,0,1,0,'h999,1,0,0,   3,1,1,1,1,0,1,0, 'h100,DB,0);
    add(0,0,1,0,'h999,1,0,0,   0,1,1,1,0,0,0,0, 'h100,DB,0);
    add(0,1,1,0,'h200,4,X5,W,  0,1,1,0,0,0,0,0, 'h100,DB,0); // 4-beat write accept
    add(0,1,0,0,'h200,4,X5,W,  1,0,0,0,1,1,0,0, 'h200,DB,W);
    add(0,1,0,0,'h200,4,X5,W,  2,1,1,0,1,0,0,0, 'h204,DB,W); // ACK_N ignored in GAP
    add(0,1,0,0,'h200,4,X5,W,  1,0,0,0,1,1,0,0, 'h204,DB,W);
    add(0,1,1,0,'h200,4,X5,W,  2,1,1,0,1,0,0,0, 'h208,DB,W);
    add(0,1,0,0,'h200,4,X5,W,  1,0,0,0,1,1,0,0, 'h208,DB,W);
    add(0,1,1,0,'h200,4,X5,W,  2,1,1,0,1,0,0,0, 'h20C,DB,W);
    add(0,1,0,0,'h200,4,X5,W,  1,0,0,1,1,1,0,0, 'h20C,DB,W); // 4th ack releases
    add(0,0,1,0,'h200,4,X5,W,  3,1,1,1,1,0,0,0, 'h20C,DB,W);
    add(0,0,1,0,'h200,4,X5,W,  0,1,1,1,0,0,0,0, 'h20C,DB,0);
    add(1,0,1,0,'h300,0,R3,0,  0,1,1,0,0,0,0,0, 'h20C,DB,0); // BURST_LEN=0 read
    add(1,0,0,0,'h300,0,R3,0,  1,0,1,1,1,0,0,0, 'h300,DB,0);
    add(0,0,1,0,'h300,0,0,0,   3,1,1,1,1,0,1,0, 'h300,R3,0);
    add(0,0,1,0,'h300,0,0,0,   0,1,1,1,0,0,0,0, 'h300,R3,0);
    add(1,1,1,0,'h300,0,0,0,   0,1,1,1,0,0,0,0, 'h300,R3,0); // MR=MW=1
    add(0,0,1,1,'h300,0,0,0,   0,1,1,1,0,0,0,1, 'h300,R3,0);
    add(1,1,1,1,'h300,0,0,0,   0,1,1,1,0,0,0,0, 'h300,R3,0); // set beats clear
    add(0,0,1,0,'h300,0,0,0,   0,1,1,1,0,0,0,1, 'h300,R3,0);
    add(0,0,1,1,'h300,0,0,0,   0,1,1,1,0,0,0,1, 'h300,R3,0);
    add(0,0,1,0,'h300,0,0,0,   0,1,1,1,0,0,0,0, 'h300,R3,0);

    RESET = 1'b1; MR = 1'b0; MW = 1'b0; ACK_N = 1'b1; ERR_CLR = 1'b0;
    ADDR_IN = 32'h0; WDATA = 32'h0; RDATA_IN = 32'h0; BURST_LEN = 3'd1;
    #12;
    chk("rst state", MAC_STATE, 2'b00);
    chk("rst as_n", AS_N, 1'b1);
    chk("rst wr_n", WR_N, 1'b1);
    chk("rst addr", BUS_ADDR, 32'h0);
    chk("rst rdata", RDATA_OUT, 32'h0);
    chk("rst busy", BUSY, 1'b0);
    chk("rst stop_n", STOP_N, 1'b1);
    chk("rst rvld", RDATA_VLD, 1'b0);
    chk("rst proto", PROTO_ERR, 1'b0);
    chk("rst tmo", TIMEOUT_ERR, 1'b0);
    tick();
    RESET = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      MR = vecs[i].mr; MW = vecs[i].mw; ACK_N = vecs[i].an; ERR_CLR = vecs[i].clr;
      ADDR_IN = vecs[i].ai; BURST_LEN = vecs[i].bl; RDATA_IN = vecs[i].rd; WDATA = vecs[i].wd;
      @(negedge CLK);
      chk($sformatf("v%0d state", i), MAC_STATE, vecs[i].st);
      chk($sformatf("v%0d as_n", i), AS_N, vecs[i].as_n);
      chk($sformatf("v%0d wr_n", i), WR_N, vecs[i].wr_n);
      chk($sformatf("v%0d stop_n", i), STOP_N, vecs[i].stop_n);
      chk($sformatf("v%0d busy", i), BUSY, vecs[i].busy);
      chk($sformatf("v%0d wdata_next", i), WDATA_NEXT, vecs[i].wnx);
      chk($sformatf("v%0d rdata_vld", i), RDATA_VLD, vecs[i].rvld);
      chk($sformatf("v%0d proto", i), PROTO_ERR, vecs[i].prot);
      chk($sformatf("v%0d tmo", i), TIMEOUT_ERR, 1'b0);
      chk($sformatf("v%0d bus_addr", i), BUS_ADDR, vecs[i].ea);
      chk($sformatf("v%0d rdata", i), RDATA_OUT, vecs[i].er);
      chk($sformatf("v%0d bus_wdata", i), BUS_WDATA, vecs[i].ebw);
      tick();
    end

    // Address wrap across the top of the address space.
    MR = 1'b1; ADDR_IN = 32'hFFFFFFFC; BURST_LEN = 3'd2; ACK_N = 1'b1;
    tick();
    ACK_N = 1'b0;
    @(negedge CLK);
    chk("wrap addr0", BUS_ADDR, 32'hFFFFFFFC);
    chk("wrap stop0", STOP_N, 1'b0);
    tick();
    ACK_N = 1'b1;
    @(negedge CLK);
    chk("wrap gap", MAC_STATE, 2'b10);
    chk("wrap addr1g", BUS_ADDR, 32'h0);
    tick();
    ACK_N = 1'b0;
    @(negedge CLK);
    chk("wrap acc2", MAC_STATE, 2'b01);
    chk("wrap addr1", BUS_ADDR, 32'h0);
    chk("wrap stop1", STOP_N, 1'b1);
    tick();
    MR = 1'b0; ACK_N = 1'b1;
    @(negedge CLK);
    chk("wrap done", MAC_STATE, 2'b11);
    tick();

    // BURST_LEN above MAX_BURST clamps to 4 beats; ACK_N held low throughout.
    MR = 1'b1; ADDR_IN = 32'h40; BURST_LEN = 3'd7; ACK_N = 1'b0; RDATA_IN = 32'h0BADF00D;
    acc_cnt = 0; vld_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (RDATA_VLD) vld_cnt++;
      if (MAC_STATE == 2'b11) break;
      if (MAC_STATE == 2'b01) acc_cnt++;
      @(posedge CLK);
      #1;
    end
    chk("clamp done", MAC_STATE, 2'b11);
    chk("clamp beats", 32'(acc_cnt), 32'd4);
    chk("clamp rvld", 32'(vld_cnt), 32'd4);
    chk("clamp addr", BUS_ADDR, 32'h4C);
    MR = 1'b0; ACK_N = 1'b1;
    tick();
    chk("clamp idle", MAC_STATE, 2'b00);

    // Reset in the GAP of a 4-beat read, then a fresh burst.
    MR = 1'b1; ADDR_IN = 32'h400; BURST_LEN = 3'd4; ACK_N = 1'b1; RDATA_IN = 32'hA5A5A5A5;
    tick();
    ACK_N = 1'b0;
    tick();
    ACK_N = 1'b1;
    @(negedge CLK);
    chk("rgap state", MAC_STATE, 2'b10);
    chk("rgap rdata", RDATA_OUT, 32'hA5A5A5A5);
    #1;
    RESET = 1'b1; MR = 1'b0; ADDR_IN = 32'h500; BURST_LEN = 3'd1;
    #1;
    chk("rgap as_n", AS_N, 1'b1);
    chk("rgap state0", MAC_STATE, 2'b00);
    chk("rgap busy", BUSY, 1'b0);
    chk("rgap rdata0", RDATA_OUT, 32'h0);
    tick();
    RESET = 1'b0; MR = 1'b1;
    @(negedge CLK);
    chk("fresh stop0", STOP_N, 1'b0);
    tick();
    ACK_N = 1'b0;
    @(negedge CLK);
    chk("fresh state", MAC_STATE, 2'b01);
    chk("fresh addr", BUS_ADDR, 32'h500);
    chk("fresh as_n", AS_N, 1'b0);
    chk("fresh stop1", STOP_N, 1'b1);
    tick();
    MR = 1'b0; ACK_N = 1'b1;
    tick();

`ifdef MAC_TIMEOUT_EN
    // Timeout after 16 unacked ACCESS cycles, remaining beats dropped.
    MR = 1'b1; ADDR_IN = 32'h600; BURST_LEN = 3'd2; ACK_N = 1'b1;
    tick();
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      chk($sformatf("tmo acc%0d", k), MAC_STATE, 2'b01);
      chk($sformatf("tmo stop%0d", k), STOP_N, (k == 16) ? 1'b1 : 1'b0);
      tick();
    end
    MR = 1'b0;
    @(negedge CLK);
    chk("tmo done", MAC_STATE, 2'b11);
    chk("tmo flag", TIMEOUT_ERR, 1'b1);
    chk("tmo as_n", AS_N, 1'b1);
    tick();
    @(negedge CLK);
    chk("tmo idle", MAC_STATE, 2'b00);
    chk("tmo sticky", TIMEOUT_ERR, 1'b1);
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    @(negedge CLK);
    chk("tmo clr", TIMEOUT_ERR, 1'b0);
`else
    // Without the timeout feature ACCESS waits indefinitely for ACK_N.
    MR = 1'b1; ADDR_IN = 32'h600; BURST_LEN = 3'd1; ACK_N = 1'b1;
    tick();
    repeat (120) tick();
    @(negedge CLK);
    chk("wait state", MAC_STATE, 2'b01);
    chk("wait stop", STOP_N, 1'b0);
    chk("wait tmo", TIMEOUT_ERR, 1'b0);
    ACK_N = 1'b0;
    #1;
    chk("wait ack stop", STOP_N, 1'b1);
    tick();
    MR = 1'b0; ACK_N = 1'b1;
    @(negedge CLK);
    chk("wait done", MAC_STATE, 2'b11);
    chk("wait tmo2", TIMEOUT_ERR, 1'b0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
